// File: rtl/reset_sequencer.sv
// Power-on reset sequencer: filters PLL lock, waits a release delay, then
// deasserts the core reset channels one at a time, a fixed stagger apart.
module reset_sequencer #(
  parameter int LOCK_FILTER   = 4,
  parameter int RELEASE_DELAY = 128,
  parameter int CHANNELS      = 2,
  parameter int STAGGER       = 16,
  parameter int LOSS_ACTION   = 1
) (
  input  logic                clk_core,
  input  logic                reset_n,
  input  logic                pll_locked,
  input  logic                sw_reset,
  output logic [CHANNELS-1:0] core_reset_n,
  output logic                ready,
  output logic                lock_lost,
  output logic [1:0]          state
);

  localparam int MAX_WAIT = (RELEASE_DELAY > STAGGER) ? RELEASE_DELAY : STAGGER;
  localparam int CW       = $clog2(MAX_WAIT + 1);
  localparam int IW       = $clog2(CHANNELS + 1);

  localparam logic [CW-1:0] DELAY_MATCH   = CW'(RELEASE_DELAY);
  localparam logic [CW-1:0] STAGGER_MATCH = CW'(STAGGER);
  localparam logic [IW-1:0] LAST_INDEX    = IW'(CHANNELS - 1);

  typedef enum logic [1:0] {
    ST_FILTER  = 2'd0,
    ST_DELAY   = 2'd1,
    ST_STAGGER = 2'd2,
    ST_RUN     = 2'd3
  } state_t;

  logic [LOCK_FILTER-1:0] window;
  logic                   stable;

  state_t                 state_q,  state_nxt;
  logic [CW-1:0]          count_q,  count_nxt;
  logic [IW-1:0]          index_q,  index_nxt;
  logic [CHANNELS-1:0]    chan_q,   chan_nxt;
  logic                   ready_q,  ready_nxt;
  logic                   lost_q,   lost_nxt;

  // pll_locked is asynchronous; the first window stage is its synchroniser.
  if (LOCK_FILTER > 1) begin : g_window_shift
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_core or negedge reset_n) begin
      if (!reset_n) window <= '0;
      else          window <= {window[LOCK_FILTER-2:0], pll_locked};
    end
  end else begin : g_window_single
    always_ff @(posedge clk_core or negedge reset_n) begin
      if (!reset_n) window <= '0;
      else          window <= pll_locked;
    end
  end

  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) stable <= 1'b0;
    else          stable <= &window;
  end

  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_FILTER;
      count_q <= '0;
      index_q <= '0;
      chan_q  <= '0;
      ready_q <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      count_q <= count_nxt;
      index_q <= index_nxt;
      chan_q  <= chan_nxt;
      ready_q <= ready_nxt;
      lost_q  <= lost_nxt;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no latch is inferred.
    state_nxt = state_q;
    count_nxt = count_q;
    index_nxt = index_q;
    chan_nxt  = chan_q;
    ready_nxt = ready_q;
    lost_nxt  = lost_q;

    // Channels are a thermometer, so channel 0 high means the sequence got far
    // enough for a lock drop to matter.
    if (!stable && chan_q[0]) lost_nxt = 1'b1;

    case (state_q)
      ST_FILTER: begin
        count_nxt = '0;
        index_nxt = '0;
        chan_nxt  = '0;
        ready_nxt = 1'b0;
        if (stable) state_nxt = ST_DELAY;
      end

      ST_DELAY, ST_STAGGER, ST_RUN: begin
        if (!stable && (state_q != ST_RUN || LOSS_ACTION != 0)) begin
          state_nxt = ST_FILTER;
          count_nxt = '0;
          index_nxt = '0;
          chan_nxt  = '0;
          ready_nxt = 1'b0;
        end else if (sw_reset) begin
          state_nxt = ST_DELAY;
          count_nxt = '0;
          index_nxt = '0;
          chan_nxt  = '0;
          ready_nxt = 1'b0;
        end else if (state_q == ST_DELAY) begin
          if (count_q == DELAY_MATCH) begin
            chan_nxt  = (chan_q << 1) | CHANNELS'(1);
            count_nxt = '0;
            index_nxt = IW'(1);
            if (CHANNELS == 1) begin
              state_nxt = ST_RUN;
              ready_nxt = 1'b1;
            end else begin
              state_nxt = ST_STAGGER;
            end
          end else begin
            count_nxt = count_q + CW'(1);
          end
        end else if (state_q == ST_STAGGER) begin
          if (count_q == STAGGER_MATCH) begin
            chan_nxt  = (chan_q << 1) | CHANNELS'(1);
            count_nxt = '0;
            index_nxt = index_q + IW'(1);
            if (index_q == LAST_INDEX) begin
              state_nxt = ST_RUN;
              ready_nxt = 1'b1;
            end
          end else begin
            count_nxt = count_q + CW'(1);
          end
        end
      end

      default: state_nxt = ST_FILTER;
    endcase
  end

  assign core_reset_n = chan_q;
  assign ready        = ready_q;
  assign lock_lost    = lost_q;
  assign state        = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: two instances (defaults, and a 3-channel
// LOSS_ACTION=0 variant); expected output changes are queued with their edge number.
module tb_reset_sequencer;

  typedef struct packed {
    logic [31:0] cyc;
    logic [11:0] val;
  } exp_t;

  logic clk_core = 1'b0;
  always #5 clk_core = ~clk_core;

  int cyc = 0;
  always @(posedge clk_core) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  logic       a_rst_n = 1'b1, a_lock = 1'b0, a_sw = 1'b0;
  logic [1:0] a_core;
  logic       a_rdy, a_lost;
  logic [1:0] a_st;

  logic       b_rst_n = 1'b1, b_lock = 1'b0, b_sw = 1'b0;
  logic [2:0] b_core;
  logic       b_rdy, b_lost;
  logic [1:0] b_st;

  reset_sequencer u_dut_a (
    .clk_core     (clk_core),
    .reset_n      (a_rst_n),
    .pll_locked   (a_lock),
    .sw_reset     (a_sw),
    .core_reset_n (a_core),
    .ready        (a_rdy),
    .lock_lost    (a_lost),
    .state        (a_st)
  );

  reset_sequencer #(
    .LOCK_FILTER   (4),
    .RELEASE_DELAY (8),
    .CHANNELS      (3),
    .STAGGER       (4),
    .LOSS_ACTION   (0)
  ) u_dut_b (
    .clk_core     (clk_core),
    .reset_n      (b_rst_n),
    .pll_locked   (b_lock),
    .sw_reset     (b_sw),
    .core_reset_n (b_core),
    .ready        (b_rdy),
    .lock_lost    (b_lost),
    .state        (b_st)
  );

  logic [11:0] a_obs, b_obs;
  assign a_obs = {6'b0, a_core, a_rdy, a_lost, a_st};
  assign b_obs = {5'b0, b_core, b_rdy, b_lost, b_st};

  exp_t q_a[$];
  exp_t q_b[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  function automatic exp_t mk(input int c, input logic [7:0] r, input logic rdy,
                              input logic lost, input logic [1:0] st);
    exp_t e;
    e.cyc = c;
    e.val = {r[5:0], rdy, lost, st};
    return e;
  endfunction

  // Monitors: any change of the observed outputs must match the next queued event.
  logic [11:0] a_prev = '0;
  exp_t        a_e;
  always @(negedge clk_core) begin
    if (a_obs !== a_prev) begin
      a_prev = a_obs;
      if (q_a.size() == 0) begin
        check($sformatf("A unexpected change @%0d", cyc), {20'b0, a_obs}, {20'b0, 12'hfff});
      end else begin
        a_e = q_a.pop_front();
        check($sformatf("A edge of change to 0x%0h", a_e.val), cyc, a_e.cyc);
        check($sformatf("A outputs @%0d", a_e.cyc), {20'b0, a_obs}, {20'b0, a_e.val});
      end
    end
  end

  logic [11:0] b_prev = '0;
  exp_t        b_e;
  always @(negedge clk_core) begin
    if (b_obs !== b_prev) begin
      b_prev = b_obs;
      if (q_b.size() == 0) begin
        check($sformatf("B unexpected change @%0d", cyc), {20'b0, b_obs}, {20'b0, 12'hfff});
      end else begin
        b_e = q_b.pop_front();
        check($sformatf("B edge of change to 0x%0h", b_e.val), cyc, b_e.cyc);
        check($sformatf("B outputs @%0d", b_e.cyc), {20'b0, b_obs}, {20'b0, b_e.val});
      end
    end
  end

  // Leaves the bench 1 time unit after the n-th following rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk_core);
    #1;
  endtask

  initial begin
    int t0;
    #1;
    a_rst_n = 1'b0;
    b_rst_n = 1'b0;

    // Reset state, sampled before anything is released.
    step(2);
    check("A reset outputs", {20'b0, a_obs}, 32'h0);
    check("B reset outputs", {20'b0, b_obs}, 32'h0);

    // A: lock rises, drops for one cycle at edge 60 while in DELAY, relocks.
    a_rst_n = 1'b1;
    step(2);
    t0 = cyc;
    q_a.push_back(mk(t0 + 6,   8'h0, 1'b0, 1'b0, 2'd1));
    q_a.push_back(mk(t0 + 62,  8'h0, 1'b0, 1'b0, 2'd0));
    q_a.push_back(mk(t0 + 66,  8'h0, 1'b0, 1'b0, 2'd1));
    q_a.push_back(mk(t0 + 195, 8'h1, 1'b0, 1'b0, 2'd2));
    q_a.push_back(mk(t0 + 212, 8'h3, 1'b1, 1'b0, 2'd3));
    a_lock = 1'b1;
    step(59);
    a_lock = 1'b0;
    step(1);
    a_lock = 1'b1;
    step(160);

    // A: one-cycle lock drop in RUN with LOSS_ACTION=1, then full relock.
    t0 = cyc;
    q_a.push_back(mk(t0 + 3,   8'h0, 1'b0, 1'b1, 2'd0));
    q_a.push_back(mk(t0 + 7,   8'h0, 1'b0, 1'b1, 2'd1));
    q_a.push_back(mk(t0 + 136, 8'h1, 1'b0, 1'b1, 2'd2));
    q_a.push_back(mk(t0 + 153, 8'h3, 1'b1, 1'b1, 2'd3));
    a_lock = 1'b0;
    step(1);
    a_lock = 1'b1;
    step(160);

    // A: three-cycle sw_reset in RUN, then async reset mid-STAGGER.
    t0 = cyc;
    q_a.push_back(mk(t0 + 1,   8'h0, 1'b0, 1'b1, 2'd1));
    q_a.push_back(mk(t0 + 132, 8'h1, 1'b0, 1'b1, 2'd2));
    q_a.push_back(mk(t0 + 140, 8'h0, 1'b0, 1'b0, 2'd0));
    a_sw = 1'b1;
    step(3);
    a_sw = 1'b0;
    step(137);
    #1;
    a_rst_n = 1'b0;
    step(3);

    // A: reset released with lock held reproduces the power-on timing.
    a_rst_n = 1'b1;
    t0 = cyc;
    q_a.push_back(mk(t0 + 6,   8'h0, 1'b0, 1'b0, 2'd1));
    q_a.push_back(mk(t0 + 135, 8'h1, 1'b0, 1'b0, 2'd2));
    q_a.push_back(mk(t0 + 152, 8'h3, 1'b1, 1'b0, 2'd3));
    step(160);

    // B: 3 channels, RELEASE_DELAY=8, STAGGER=4.
    b_rst_n = 1'b1;
    step(2);
    t0 = cyc;
    q_b.push_back(mk(t0 + 6,  8'h0, 1'b0, 1'b0, 2'd1));
    q_b.push_back(mk(t0 + 15, 8'h1, 1'b0, 1'b0, 2'd2));
    q_b.push_back(mk(t0 + 20, 8'h3, 1'b0, 1'b0, 2'd2));
    q_b.push_back(mk(t0 + 25, 8'h7, 1'b1, 1'b0, 2'd3));
    b_lock = 1'b1;
    step(30);

    // B: lock drop in RUN with LOSS_ACTION=0 only sets the sticky flag.
    t0 = cyc;
    q_b.push_back(mk(t0 + 3, 8'h7, 1'b1, 1'b1, 2'd3));
    b_lock = 1'b0;
    step(1);
    b_lock = 1'b1;
    step(12);

    // B: async reset, then sw_reset held through FILTER and into DELAY.
    t0 = cyc;
    q_b.push_back(mk(t0, 8'h0, 1'b0, 1'b0, 2'd0));
    #1;
    b_rst_n = 1'b0;
    b_lock  = 1'b0;
    step(2);
    b_rst_n = 1'b1;
    b_sw    = 1'b1;
    step(5);
    t0 = cyc;
    q_b.push_back(mk(t0 + 6,  8'h0, 1'b0, 1'b0, 2'd1));
    q_b.push_back(mk(t0 + 29, 8'h1, 1'b0, 1'b0, 2'd2));
    q_b.push_back(mk(t0 + 34, 8'h3, 1'b0, 1'b0, 2'd2));
    q_b.push_back(mk(t0 + 39, 8'h7, 1'b1, 1'b0, 2'd3));
    b_lock = 1'b1;
    step(20);
    b_sw = 1'b0;
    step(30);

    check("A expected events left over", q_a.size(), 32'd0);
    check("B expected events left over", q_b.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
